core_fetch: RTL and testbench

Instruction fetch stage directly upstream of the core instruction decoder. Owns the PC and drives a synchronous instruction BRAM with fixed 1-cycle read latency. Presents a registered INST/INST_PC/INST_VALID triple to decode every cycle. Handles downstream stall with a one-entry hold buffer and redirects (branch/jump) with squash of in-flight fetches.

---
 rtl/core_fetch.sv | 106 ++++++++++
 tb/tb_core_fetch.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/core_fetch.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle BRAM and presents
// a registered instruction to decode, with a one-entry stall hold buffer.
module core_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_EN,
    output logic [29:0] IMEM_ADDR,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] INST,
    output logic [31:0] INST_PC,
    output logic        INST_VALID
);

    logic [31:0] pc_q, pc_d;
    logic        infl_v_q, infl_v_d;
    logic [31:0] infl_pc_q, infl_pc_d;
    logic        hold_v_q, hold_v_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_v_q, inst_v_d;

    logic        src_v;
    logic [31:0] src_data;
    logic [31:0] src_pc;

    assign IMEM_EN    = !STALL && !REDIRECT && RST_N;
    assign IMEM_ADDR  = pc_q[31:2];
    assign INST       = inst_q;
    assign INST_PC    = inst_pc_q;
    assign INST_VALID = inst_v_q;

    // The hold buffer always predates any in-flight response.
    assign src_v    = hold_v_q || infl_v_q;
    assign src_data = hold_v_q ? hold_data_q : IMEM_RDATA;
    assign src_pc   = hold_v_q ? hold_pc_q : infl_pc_q;

    always_comb begin
        pc_d        = pc_q;
        infl_v_d    = 1'b0;
        infl_pc_d   = infl_pc_q;
        hold_v_d    = hold_v_q;
        hold_data_d = hold_data_q;
        hold_pc_d   = hold_pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        inst_v_d    = inst_v_q;
        if (REDIRECT) begin
            pc_d     = REDIRECT_PC & ~32'h3;
            hold_v_d = 1'b0;
            inst_d   = NOP_INST;
            inst_v_d = 1'b0;
        end else if (STALL) begin
            if (infl_v_q) begin
                hold_v_d    = 1'b1;
                hold_data_d = IMEM_RDATA;
                hold_pc_d   = infl_pc_q;
            end
        end else begin
            pc_d      = pc_q + 32'd4;
            infl_v_d  = 1'b1;
            infl_pc_d = pc_q;
            hold_v_d  = 1'b0;
            if (src_v) begin
                inst_d    = src_data;
                inst_pc_d = src_pc;
                inst_v_d  = 1'b1;
            end else begin
                inst_d   = NOP_INST;
                inst_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_q        <= RESET_PC;
            infl_v_q    <= 1'b0;
            infl_pc_q   <= 32'd0;
            hold_v_q    <= 1'b0;
            hold_data_q <= 32'd0;
            hold_pc_q   <= 32'd0;
            inst_q      <= NOP_INST;
            inst_pc_q   <= 32'd0;
            inst_v_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            infl_v_q    <= infl_v_d;
            infl_pc_q   <= infl_pc_d;
            hold_v_q    <= hold_v_d;
            hold_data_q <= hold_data_d;
            hold_pc_q   <= hold_pc_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            inst_v_q    <= inst_v_d;
        end
    end

endmodule

// File: tb/tb_core_fetch.sv
// Directed, table-driven bench for core_fetch plus a PC wrap sequence
// on a second instance with a high reset PC.
module tb_core_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = 32'd0;

    logic        en, w_en;
    logic [29:0] addr, w_addr;
    logic [31:0] rdata = 32'd0, w_rdata = 32'd0;
    logic [31:0] inst, w_inst;
    logic [31:0] ipc, w_ipc;
    logic        ival, w_ival;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    core_fetch u_dut (
        .CLK(clk), .RST_N(rst_n), .STALL(stall), .REDIRECT(redir),
        .REDIRECT_PC(rpc), .IMEM_EN(en), .IMEM_ADDR(addr),
        .IMEM_RDATA(rdata), .INST(inst), .INST_PC(ipc), .INST_VALID(ival)
    );

    core_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .CLK(clk), .RST_N(rst_n), .STALL(stall), .REDIRECT(redir),
        .REDIRECT_PC(rpc), .IMEM_EN(w_en), .IMEM_ADDR(w_addr),
        .IMEM_RDATA(w_rdata), .INST(w_inst), .INST_PC(w_ipc),
        .INST_VALID(w_ival)
    );

    // BRAM models: word n holds BASE + n
    always @(posedge clk) begin
        if (en) rdata <= BASE + {2'b00, addr};
        if (w_en) w_rdata <= BASE + {2'b00, w_addr};
    end

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        en;
        logic        val;
        logic [31:0] pc;
        logic        ca;
        logic [29:0] addr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic s, input logic d,
                       input logic [31:0] t, input logic e,
                       input logic v, input logic [31:0] p,
                       input logic ca, input logic [29:0] a);
        vec_t x;
        x.rst_n = r; x.stall = s; x.redir = d; x.rpc = t;
        x.en = e; x.val = v; x.pc = p; x.ca = ca; x.addr = a;
        vq.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    initial begin
        // rst stall redir rpc en | val pc | check-addr addr
        add(0, 0, 0, 0,      0, 0, 0,      1, 30'h0);
        add(0, 0, 0, 0,      0, 0, 0,      1, 30'h0);
        add(1, 0, 0, 0,      1, 0, 0,      1, 30'h1);
        add(1, 0, 0, 0,      1, 1, 0,      0, 0);
        add(1, 0, 0, 0,      1, 1, 4,      0, 0);
        add(1, 0, 0, 0,      1, 1, 8,      0, 0);
        add(1, 1, 0, 0,      0, 1, 8,      1, 30'h4);
        add(1, 1, 0, 0,      0, 1, 8,      0, 0);
        add(1, 1, 0, 0,      0, 1, 8,      0, 0);
        add(1, 0, 0, 0,      1, 1, 12,     0, 0);
        add(1, 0, 0, 0,      1, 1, 16,     0, 0);
        add(1, 0, 0, 0,      1, 1, 20,     0, 0);
        add(1, 0, 1, 32'h103, 0, 0, 0,     1, 30'h40);
        add(1, 0, 0, 0,      1, 0, 0,      1, 30'h41);
        add(1, 0, 0, 0,      1, 1, 32'h100, 0, 0);
        add(1, 0, 0, 0,      1, 1, 32'h104, 0, 0);
        add(1, 1, 0, 0,      0, 1, 32'h104, 0, 0);
        add(0, 1, 0, 0,      0, 0, 0,      1, 30'h0);
        add(1, 0, 0, 0,      1, 0, 0,      0, 0);
        add(1, 0, 0, 0,      1, 1, 0,      0, 0);
        add(1, 0, 0, 0,      1, 1, 4,      0, 0);
        add(1, 1, 0, 0,      0, 1, 4,      0, 0);
        add(1, 1, 0, 0,      0, 1, 4,      0, 0);
        add(1, 1, 1, 32'h200, 0, 0, 0,     1, 30'h80);
        add(1, 1, 0, 0,      0, 0, 0,      1, 30'h80);
        add(1, 0, 0, 0,      1, 0, 0,      0, 0);
        add(1, 0, 0, 0,      1, 1, 32'h200, 0, 0);
        add(1, 0, 0, 0,      1, 1, 32'h204, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst_n = vq[i].rst_n;
            stall = vq[i].stall;
            redir = vq[i].redir;
            rpc   = vq[i].rpc;
            #1;
            chk($sformatf("en[%0d]", i), {31'd0, en}, {31'd0, vq[i].en});
            @(posedge clk);
            #1;
            chk($sformatf("valid[%0d]", i), {31'd0, ival},
                {31'd0, vq[i].val});
            if (vq[i].val) begin
                chk($sformatf("inst[%0d]", i), inst,
                    BASE + (vq[i].pc >> 2));
                chk($sformatf("pc[%0d]", i), ipc, vq[i].pc);
            end else begin
                chk($sformatf("nop[%0d]", i), inst, NOP);
            end
            if (vq[i].ca)
                chk($sformatf("addr[%0d]", i), {2'b00, addr},
                    {2'b00, vq[i].addr});
        end

        // PC wrap on the high-reset-PC instance
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; redir = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("wrap_addr", {2'b00, w_addr}, 32'h3FFF_FFFE);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] ep;
            ep = 32'hFFFF_FFF8 + 32'(k * 4);
            @(posedge clk);
            #1;
            chk($sformatf("wrap_val%0d", k), {31'd0, w_ival}, 32'd1);
            chk($sformatf("wrap_pc%0d", k), w_ipc, ep);
            chk($sformatf("wrap_inst%0d", k), w_inst, BASE + (ep >> 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
